id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage datapath.
- Captures decoded operands and control from ID and presents EXrs/EXrt/EXrd plus control to the EX stage and to the forwarding unit.
- Inserts bubbles on load-use hazards, stalling PC and IF/ID. Also inserts bubbles on branch flush.

Parameters:
- STALL_CYCLES, 1, total cycles the ID instruction is held on a load-use hazard; legal range 1..7. 1 = full forwarding present; 2 = no MEM/WB load forwarding.

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- IDrs, IDrt, IDrd  in  5 each  register specifiers from decode
- IDUsesRt  in  1  1 when rt is a source operand (R-type, beq, sw)
- IDReadData1, IDReadData2  in  32 each  register file read data
- IDImm  in  32  sign-extended immediate
- IDRegWrite, IDMemRead, IDMemWrite, IDMemToReg, IDALUSrc, IDRegDst  in  1 each  decoded control
- IDALUOp  in  4  ALU operation select
- Flush  in  1  squash instruction currently in ID (taken branch/jump)
- EXrs, EXrt, EXrd  out  5 each  registered specifiers
- EXReadData1, EXReadData2, EXImm  out  32 each  registered data
- EXRegWrite, EXMemRead, EXMemWrite, EXMemToReg, EXALUSrc, EXRegDst  out  1 each  registered control
- EXALUOp  out  4  registered ALU op
- EXValid  out  1  1 = real instruction in EX, 0 = bubble
- Stall  out  1  hazard stall active (combinational)
- PCWrite, IFIDWrite  out  1 each  equal to ~Stall

Behaviour:
- Reset: every registered output is 0 (EXValid=0). FSM goes to RUN and cnt=0. Stall=0, PCWrite=IFIDWrite=1 while Rst is high.
- Bubble: all EX control, data and specifier fields = 0, EXValid=0. Zeroed specifiers keep forwarding from matching.
- Hazard H (combinational, on registered EX fields): EXMemRead && EXrt!=0 && (EXrt==IDrs || (IDUsesRt && EXrt==IDrt)).
- FSM states are RUN and HOLD; cnt is 3 bits.
- RUN:
  - Stall = H && !Flush.
  - If Stall, the edge loads a bubble. If STALL_CYCLES>1, state goes to HOLD and cnt loads STALL_CYCLES-2.
  - Otherwise the edge loads ID fields with EXValid=1.
- HOLD:
  - Stall = !Flush.
  - Each edge loads a bubble.
  - If cnt==0, go to RUN; else cnt decrements.
- Total stall: exactly STALL_CYCLES cycles per hazard, after which the held instruction enters EX.
- Flush has highest priority:
  - The edge loads a bubble, state goes to RUN, cnt=0.
  - Stall=0 in a flush cycle, so IF/ID refills.
- Latency: non-stalled ID fields appear on EX outputs 1 cycle after the capturing edge.
- Back-to-back loads: after a stall releases, a dependent load in ID is re-evaluated against the new EX instruction. Chained hazards stall again.
- IDrs==0 or IDrt==0 against EXrt==0 never stalls.
- Rst mid-HOLD: immediate return to reset values. No partial stall survives.

Test Plan:
- Reset: Rst=1 mid-run with random ID inputs -> all EX outputs 0, EXValid=0, Stall=0, PCWrite=1 asynchronously, before the next edge.
- Pass-through: IDrs=3, IDrt=4, IDrd=5, IDReadData1=0x11, IDRegWrite=1, no hazard -> next cycle EXrs=3, EXrt=4, EXrd=5, EXReadData1=0x11, EXRegWrite=1, EXValid=1.
- Load-use, STALL_CYCLES=1: lw $8 in EX (EXMemRead=1, EXrt=8), add with IDrs=8 -> Stall=1 for 1 cycle, then one bubble (EXValid=0), then add in EX with EXrs=8. PC held one cycle.
- Load-use, STALL_CYCLES=2: same sequence -> Stall high 2 consecutive cycles, 2 bubbles, then add enters EX. Repeat with IDUsesRt=0, IDrt=8, IDrs=9 -> no stall.
- Flush priority: hazard present and Flush=1 in same cycle -> Stall=0, bubble loaded, state RUN. Repeat with Flush=1 during HOLD -> HOLD aborted, Stall drops that cycle.
- Zero register: EXMemRead=1, EXrt=0, IDrs=0 -> Stall=0, instruction passes unchanged.

Source files
------------

// File: rtl/id_ex_hazard_stage_if.sv
// ID-to-EX stage bundle: decoded ID fields and flush in, registered EX fields and stall controls out.
// The master side is the surrounding pipeline; the slave side is the ID/EX stage itself.
interface id_ex_hazard_stage_if;
    logic [4:0]  IDrs;
    logic [4:0]  IDrt;
    logic [4:0]  IDrd;
    logic        IDUsesRt;
    logic [31:0] IDReadData1;
    logic [31:0] IDReadData2;
    logic [31:0] IDImm;
    logic        IDRegWrite;
    logic        IDMemRead;
    logic        IDMemWrite;
    logic        IDMemToReg;
    logic        IDALUSrc;
    logic        IDRegDst;
    logic [3:0]  IDALUOp;
    logic        Flush;

    logic [4:0]  EXrs;
    logic [4:0]  EXrt;
    logic [4:0]  EXrd;
    logic [31:0] EXReadData1;
    logic [31:0] EXReadData2;
    logic [31:0] EXImm;
    logic        EXRegWrite;
    logic        EXMemRead;
    logic        EXMemWrite;
    logic        EXMemToReg;
    logic        EXALUSrc;
    logic        EXRegDst;
    logic [3:0]  EXALUOp;
    logic        EXValid;
    logic        Stall;
    logic        PCWrite;
    logic        IFIDWrite;

    modport master (
        output IDrs, IDrt, IDrd, IDUsesRt, IDReadData1, IDReadData2, IDImm,
               IDRegWrite, IDMemRead, IDMemWrite, IDMemToReg, IDALUSrc, IDRegDst, IDALUOp, Flush,
        input  EXrs, EXrt, EXrd, EXReadData1, EXReadData2, EXImm,
               EXRegWrite, EXMemRead, EXMemWrite, EXMemToReg, EXALUSrc, EXRegDst, EXALUOp,
               EXValid, Stall, PCWrite, IFIDWrite
    );

    modport slave (
        input  IDrs, IDrt, IDrd, IDUsesRt, IDReadData1, IDReadData2, IDImm,
               IDRegWrite, IDMemRead, IDMemWrite, IDMemToReg, IDALUSrc, IDRegDst, IDALUOp, Flush,
        output EXrs, EXrt, EXrd, EXReadData1, EXReadData2, EXImm,
               EXRegWrite, EXMemRead, EXMemWrite, EXMemToReg, EXALUSrc, EXRegDst, EXALUOp,
               EXValid, Stall, PCWrite, IFIDWrite
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection; a hazard holds PC and IF/ID for
// STALL_CYCLES cycles while bubbles enter EX. Flush squashes ID and overrides any stall.
module id_ex_hazard_stage #(
    parameter int unsigned STALL_CYCLES = 1
) (
    input logic                 Clk,
    input logic                 Rst,
    id_ex_hazard_stage_if.slave bus
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  alu_op;
        logic        valid;
    } ex_fields_t;

    // First cycle of a hazard is spent in RUN, so HOLD covers the remaining STALL_CYCLES-1.
    localparam logic [2:0] HoldInit = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 2) : 3'd0;

    state_e     state_q;
    logic [2:0] cnt_q;
    ex_fields_t ex_q;
    ex_fields_t id_fields;
    logic       hazard;
    logic       stall;

    assign id_fields = '{
        rs:         bus.IDrs,
        rt:         bus.IDrt,
        rd:         bus.IDrd,
        read_data1: bus.IDReadData1,
        read_data2: bus.IDReadData2,
        imm:        bus.IDImm,
        reg_write:  bus.IDRegWrite,
        mem_read:   bus.IDMemRead,
        mem_write:  bus.IDMemWrite,
        mem_to_reg: bus.IDMemToReg,
        alu_src:    bus.IDALUSrc,
        reg_dst:    bus.IDRegDst,
        alu_op:     bus.IDALUOp,
        valid:      1'b1
    };

    // $zero never carries a load result, so a zero EXrt can not create a dependency.
    assign hazard = ex_q.mem_read && (ex_q.rt != 5'd0) &&
                    ((ex_q.rt == bus.IDrs) || (bus.IDUsesRt && (ex_q.rt == bus.IDrt)));

    always_comb begin
        stall = 1'b0;
        case (state_q)
            StRun:   stall = hazard && !bus.Flush;
            StHold:  stall = !bus.Flush;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
            ex_q    <= '0;
        end else if (bus.Flush) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
            ex_q    <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (hazard) begin
                        ex_q <= '0;
                        if (STALL_CYCLES > 1) begin
                            state_q <= StHold;
                            cnt_q   <= HoldInit;
                        end
                    end else begin
                        ex_q <= id_fields;
                    end
                end
                StHold: begin
                    ex_q <= '0;
                    if (cnt_q == 3'd0) begin
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= StRun;
                    cnt_q   <= 3'd0;
                    ex_q    <= '0;
                end
            endcase
        end
    end

    assign bus.EXrs        = ex_q.rs;
    assign bus.EXrt        = ex_q.rt;
    assign bus.EXrd        = ex_q.rd;
    assign bus.EXReadData1 = ex_q.read_data1;
    assign bus.EXReadData2 = ex_q.read_data2;
    assign bus.EXImm       = ex_q.imm;
    assign bus.EXRegWrite  = ex_q.reg_write;
    assign bus.EXMemRead   = ex_q.mem_read;
    assign bus.EXMemWrite  = ex_q.mem_write;
    assign bus.EXMemToReg  = ex_q.mem_to_reg;
    assign bus.EXALUSrc    = ex_q.alu_src;
    assign bus.EXRegDst    = ex_q.reg_dst;
    assign bus.EXALUOp     = ex_q.alu_op;
    assign bus.EXValid     = ex_q.valid;
    assign bus.Stall       = stall;
    assign bus.PCWrite     = !stall;
    assign bus.IFIDWrite   = !stall;

endmodule
